// File: rtl/cpu_mc_if.sv
// Bus bundle between the multi-cycle core and its instruction/data memories.
// The core side uses the master modport; memories and the bench use slave.
interface cpu_mc_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [3:0]  data_we;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        halted;
  logic [1:0]  trap_cause;

  modport master (
    output inst_req, inst_addr, input inst_ready, inst_rdata,
    output data_req, data_addr, data_we, data_wdata, input data_ready, data_rdata,
    output halted, trap_cause
  );

  modport slave (
    input inst_req, inst_addr, output inst_ready, inst_rdata,
    input data_req, data_addr, data_we, data_wdata, output data_ready, data_rdata,
    input halted, trap_cause
  );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> (MEM) -> FETCH, HALT on trap.
//   state | meaning
//   FETCH | inst_req held with inst_addr=pc until inst_ready, IR latched
//   EXEC  | one cycle: decode, ALU, branch/jump, writeback or address generation
//   MEM   | data_req held with fixed addr/we/wdata until data_ready
//   HALT  | trapped; no requests until rst
module cpu_mc #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic      clk,
  input logic      rst,
  cpu_mc_if.master bus
);
  localparam int        RIW   = (NUM_REGS == 16) ? 4 : 5;
  localparam logic [5:0] NREG6 = 6'(NUM_REGS);

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
                         OPC_JALR = 7'h67, OPC_BR = 7'h63, OPC_LD = 7'h03,
                         OPC_ST = 7'h23, OPC_OPI = 7'h13, OPC_OP = 7'h33,
                         OPC_SYS = 7'h73;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, data_addr_q, data_wdata_q;
  logic [3:0]  data_we_q;
  logic [1:0]  ea_lo_q, trap_q;
  logic        inst_req_q, data_req_q, halted_q;
  logic [31:0] regs_q [NUM_REGS];

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, alu_b, alu_r, wb_d, npc_d, ea_d, wdata_d, lsh, load_d;
  logic [3:0]  we_d;
  logic        alt, taken, illegal, bad_idx, use_rd, use_rs1, use_rs2;
  logic        is_mem, is_store, jump, ecall, mis;
  logic [1:0]  trap_d;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Operand read (x0 and out-of-range indices read as zero) and ALU
  always_comb begin
    rs1_v = ({1'b0, rs1} < NREG6 && rs1 != 5'd0) ? regs_q[rs1[RIW-1:0]] : 32'h0;
    rs2_v = ({1'b0, rs2} < NREG6 && rs2 != 5'd0) ? regs_q[rs2[RIW-1:0]] : 32'h0;
    alu_b = (opc == OPC_OP) ? rs2_v : imm_i;
    // funct7[5] only selects SUB/SRA for OP, and only SRAI for OP-IMM
    alt   = (opc == OPC_OP) ? f7[5] : (f3 == 3'd5 && f7[5]);
    alu_r = 32'h0;
    case (f3)
      3'd0: alu_r = alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_r = rs1_v << alu_b[4:0];
      3'd2: alu_r = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_r = {31'b0, rs1_v < alu_b};
      3'd4: alu_r = rs1_v ^ alu_b;
      3'd5: alu_r = alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6: alu_r = rs1_v | alu_b;
      default: alu_r = rs1_v & alu_b;
    endcase
    taken = 1'b0;
    case (f3)
      3'd0: taken = (rs1_v == rs2_v);
      3'd1: taken = (rs1_v != rs2_v);
      3'd4: taken = ($signed(rs1_v) < $signed(rs2_v));
      3'd5: taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6: taken = (rs1_v < rs2_v);
      3'd7: taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  // Instruction decode: writeback value, next pc, memory request and trap cause
  always_comb begin
    illegal = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    is_mem = 1'b0; is_store = 1'b0; jump = 1'b0; ecall = 1'b0;
    wb_d = alu_r; npc_d = pc_q + 32'd4; ea_d = rs1_v + imm_i;
    case (opc)
      OPC_LUI:   begin use_rd = 1'b1; wb_d = imm_u; end
      OPC_AUIPC: begin use_rd = 1'b1; wb_d = pc_q + imm_u; end
      OPC_JAL:   begin use_rd = 1'b1; wb_d = pc_q + 32'd4; npc_d = pc_q + imm_j; jump = 1'b1; end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wb_d = pc_q + 32'd4; jump = 1'b1;
        npc_d = (rs1_v + imm_i) & ~32'h1;
        illegal = (f3 != 3'd0);
      end
      OPC_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        illegal = (f3 == 3'd2 || f3 == 3'd3);
        if (taken) begin npc_d = pc_q + imm_b; jump = 1'b1; end
      end
      OPC_LD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
        illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      OPC_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; is_store = 1'b1;
        ea_d = rs1_v + imm_s;
        illegal = (f3 > 3'd2);
      end
      OPC_OPI: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                  (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OPC_SYS: ecall = 1'b1;
      default: illegal = 1'b1;
    endcase
    bad_idx = (use_rd && {1'b0, rd} >= NREG6) || (use_rs1 && {1'b0, rs1} >= NREG6) ||
              (use_rs2 && {1'b0, rs2} >= NREG6);
    mis = (is_mem && ((f3[1:0] == 2'd1 && ea_d[0]) || (f3[1:0] == 2'd2 && ea_d[1:0] != 2'd0))) ||
          (jump && npc_d[1]);
    trap_d = ecall ? 2'd3 : (illegal || bad_idx) ? 2'd1 : mis ? 2'd2 : 2'd0;
    case (f3[1:0])
      2'd0:    we_d = 4'b0001 << ea_d[1:0];
      2'd1:    we_d = 4'b0011 << ea_d[1:0];
      default: we_d = 4'b1111;
    endcase
    wdata_d = rs2_v << {ea_d[1:0], 3'b000};
    lsh = bus.data_rdata >> {ea_lo_q, 3'b000};
    case (f3)
      3'd0:    load_d = {{24{lsh[7]}}, lsh[7:0]};
      3'd1:    load_d = {{16{lsh[15]}}, lsh[15:0]};
      3'd4:    load_d = {24'b0, lsh[7:0]};
      3'd5:    load_d = {16'b0, lsh[15:0]};
      default: load_d = lsh;
    endcase
  end

  // Control FSM with registered bus outputs, pc and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0;
      inst_req_q   <= 1'b0;
      data_req_q   <= 1'b0;
      data_addr_q  <= 32'h0;
      data_we_q    <= 4'h0;
      data_wdata_q <= 32'h0;
      ea_lo_q      <= 2'd0;
      halted_q     <= 1'b0;
      trap_q       <= 2'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!inst_req_q) begin
            inst_req_q <= 1'b1;
          end else if (bus.inst_ready) begin
            ir_q       <= bus.inst_rdata;
            inst_req_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (trap_d != 2'd0) begin
            halted_q <= 1'b1;
            trap_q   <= trap_d;
            state_q  <= S_HALT;
          end else if (is_mem) begin
            data_req_q   <= 1'b1;
            data_addr_q  <= {ea_d[31:2], 2'b00};
            data_we_q    <= is_store ? we_d : 4'h0;
            data_wdata_q <= is_store ? wdata_d : 32'h0;
            ea_lo_q      <= ea_d[1:0];
            state_q      <= S_MEM;
          end else begin
            if (use_rd && rd != 5'd0) regs_q[rd[RIW-1:0]] <= wb_d;
            pc_q       <= npc_d;
            inst_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.data_ready) begin
            if (!is_store && rd != 5'd0) regs_q[rd[RIW-1:0]] <= load_d;
            data_req_q <= 1'b0;
            data_we_q  <= 4'h0;
            pc_q       <= pc_q + 32'd4;
            inst_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inst_req   = inst_req_q;
  assign bus.inst_addr  = pc_q;
  assign bus.data_req   = data_req_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_we    = data_we_q;
  assign bus.data_wdata = data_wdata_q;
  assign bus.halted     = halted_q;
  assign bus.trap_cause = trap_q;
endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: small programs per scenario, checked against
// hand-computed register, pc, trap and bus values.
module tb_cpu_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_mc_if bus();
  cpu_mc_if bus16();

  cpu_mc #(.NUM_REGS(32), .RESET_PC(32'h0))  dut   (.clk(clk), .rst(rst), .bus(bus));
  cpu_mc #(.NUM_REGS(16), .RESET_PC(32'h80)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:255];
  int dly = 0;
  int dwait_q = 0;

  assign bus.inst_rdata = imem[bus.inst_addr[7:2]];
  assign bus.inst_ready = bus.inst_req;
  assign bus.data_rdata = dmem[bus.data_addr[9:2]];
  assign bus.data_ready = bus.data_req && (dwait_q >= dly);

  // RV32E instance always fetches ADD x20,x1,x2
  assign bus16.inst_rdata = 32'h00208A33;
  assign bus16.inst_ready = bus16.inst_req;
  assign bus16.data_rdata = 32'h0;
  assign bus16.data_ready = bus16.data_req;

  int cyc = 0, both_cnt = 0, store_cnt = 0, dreq_cycles = 0;
  logic [31:0] st_addr = 32'h0, st_wdata = 32'h0;
  logic [3:0]  st_we = 4'h0;
  int fetch_cyc [0:63];

  // Data wait-state counter and store capture
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dwait_q <= (bus.data_req && !bus.data_ready) ? dwait_q + 1 : 0;
    if (bus.data_req && bus.data_ready && bus.data_we != 4'h0) begin
      store_cnt <= store_cnt + 1;
      st_addr   <= bus.data_addr;
      st_we     <= bus.data_we;
      st_wdata  <= bus.data_wdata;
    end
  end

  // Fetch timestamps and bus-exclusivity monitor
  always @(negedge clk) begin
    if (bus.inst_req && bus.inst_ready) fetch_cyc[bus.inst_addr[7:2]] <= cyc;
    if (bus.inst_req && bus.data_req) both_cnt <= both_cnt + 1;
    if (bus.data_req) dreq_cycles <= dreq_cycles + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rg(input logic [4:0] i);
    return dut.regs_q[i];
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h00000073;
  endtask

  task automatic reset_core();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!bus.halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, 32'(bus.halted), 32'h1);
  endtask

  task automatic wait_dreq(input string tag);
    int n = 0;
    while (!bus.data_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, 32'(bus.data_req), 32'h1);
  endtask

  int s0;

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    dmem[8'h80] = 32'h8001_1234;

    // ---- reset state, then ADDI/SRAI/SLTU with zero wait states
    clear_imem();
    imem[0] = 32'hFFB00093;  // addi x1,x0,-5
    imem[1] = 32'h4010D113;  // srai x2,x1,1
    imem[2] = 32'h001031B3;  // sltu x3,x0,x1
    repeat (2) @(negedge clk);
    chk("rst_inst_req",   32'(bus.inst_req), 32'h0);
    chk("rst_data_req",   32'(bus.data_req), 32'h0);
    chk("rst_halted",     32'(bus.halted), 32'h0);
    chk("rst_trap_cause", 32'(bus.trap_cause), 32'h0);
    chk("rst_data_we",    32'(bus.data_we), 32'h0);
    chk("rst_data_addr",  bus.data_addr, 32'h0);
    chk("rst_data_wdata", bus.data_wdata, 32'h0);
    chk("rst_pc",         bus.inst_addr, 32'h0);
    chk("rst_pc16",       bus16.inst_addr, 32'h80);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_inst_req",  32'(bus.inst_req), 32'h1);
    chk("first_inst_addr", bus.inst_addr, 32'h0);
    wait_halt("alu1");
    chk("x1_addi", rg(1), 32'hFFFFFFFB);
    chk("x2_srai", rg(2), 32'hFFFFFFFD);
    chk("x3_sltu", rg(3), 32'h1);
    chk("t_addi", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd2);
    chk("t_srai", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd2);
    chk("t_sltu", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd2);
    chk("ecall_cause", 32'(bus.trap_cause), 32'd3);
    chk("ecall_pc", dut.pc_q, 32'hC);
    repeat (3) @(negedge clk);
    chk("halt_inst_req", 32'(bus.inst_req), 32'h0);
    chk("halt_data_req", 32'(bus.data_req), 32'h0);
    chk("halt_stays",    32'(bus.halted), 32'h1);
    chk("rv32e_halted",  32'(bus16.halted), 32'h1);
    chk("rv32e_cause",   32'(bus16.trap_cause), 32'd1);
    chk("rv32e_pc",      dut16.pc_q, 32'h80);

    // ---- LUI/AUIPC/SUB/XORI/SLT/SLLI and rd==rs1
    clear_imem();
    imem[0] = 32'h123450B7;  // lui x1,0x12345
    imem[1] = 32'h00001117;  // auipc x2,1
    imem[2] = 32'h402081B3;  // sub x3,x1,x2
    imem[3] = 32'hFFF0C213;  // xori x4,x1,-1
    imem[4] = 32'h001222B3;  // slt x5,x4,x1
    imem[5] = 32'h00409313;  // slli x6,x1,4
    imem[6] = 32'h001080B3;  // add x1,x1,x1
    reset_core();
    wait_halt("alu2");
    chk("x2_auipc", rg(2), 32'h00001004);
    chk("x3_sub",   rg(3), 32'h12343FFC);
    chk("x4_xori",  rg(4), 32'hEDCBAFFF);
    chk("x5_slt",   rg(5), 32'h1);
    chk("x6_slli",  rg(6), 32'h23450000);
    chk("x1_add_self", rg(1), 32'h2468A000);

    // ---- SB to 0x103 with 3 wait states
    clear_imem();
    imem[0] = 32'h0A500293;  // addi x5,x0,0xA5
    imem[1] = 32'h10000313;  // addi x6,x0,0x100
    imem[2] = 32'h005301A3;  // sb x5,3(x6)
    dly = 3;
    s0 = store_cnt;
    reset_core();
    wait_dreq("sb");
    for (int k = 0; k < 4; k++) begin
      chk("sb_req",   32'(bus.data_req), 32'h1);
      chk("sb_addr",  bus.data_addr, 32'h100);
      chk("sb_we",    32'(bus.data_we), 32'h8);
      chk("sb_wdata", bus.data_wdata, 32'hA5000000);
      @(negedge clk);
    end
    chk("sb_req_drop", 32'(bus.data_req), 32'h0);
    wait_halt("sb");
    chk("sb_count", 32'(store_cnt - s0), 32'd1);
    chk("sb_st_we", 32'(st_we), 32'h8);
    chk("sb_pc", dut.pc_q, 32'hC);

    // ---- LH / LHU / LW from 0x202 / 0x200
    clear_imem();
    imem[0] = 32'h20000313;  // addi x6,x0,0x200
    imem[1] = 32'h00231383;  // lh x7,2(x6)
    imem[2] = 32'h00235403;  // lhu x8,2(x6)
    imem[3] = 32'h00032483;  // lw x9,0(x6)
    dly = 1;
    reset_core();
    wait_halt("ld");
    chk("x7_lh",  rg(7), 32'hFFFF8001);
    chk("x8_lhu", rg(8), 32'h00008001);
    chk("x9_lw",  rg(9), 32'h80011234);

    // ---- misaligned LW: no access, pc held
    clear_imem();
    imem[0] = 32'h00600313;  // addi x6,x0,6
    imem[1] = 32'h00032383;  // lw x7,0(x6)
    s0 = dreq_cycles;
    reset_core();
    wait_halt("mis");
    chk("mis_cause", 32'(bus.trap_cause), 32'd2);
    chk("mis_pc",    dut.pc_q, 32'h4);
    chk("mis_noreq", 32'(dreq_cycles - s0), 32'd0);
    chk("mis_x7",    rg(7), 32'h0);

    // ---- bad funct7 (MUL) is illegal
    clear_imem();
    imem[0] = 32'h022081B3;  // mul x3,x1,x2
    reset_core();
    wait_halt("ill");
    chk("ill_cause", 32'(bus.trap_cause), 32'd1);
    chk("ill_pc",    dut.pc_q, 32'h0);

    // ---- BNE taken backwards from 0x40
    clear_imem();
    imem[0]  = 32'h00100093;  // addi x1,x0,1
    imem[1]  = 32'h03C0006F;  // jal x0,+0x3C
    imem[16] = 32'hFE009CE3;  // bne x1,x0,-8
    reset_core();
    wait_halt("bne");
    chk("bne_pc",     dut.pc_q, 32'h38);
    chk("bne_cause",  32'(bus.trap_cause), 32'd3);
    chk("bne_target", 32'(fetch_cyc[14] - fetch_cyc[16]), 32'd2);

    // ---- JALR to 0x102 faults, x1 untouched
    clear_imem();
    imem[0] = 32'h10000293;  // addi x5,x0,0x100
    imem[1] = 32'h003280E7;  // jalr x1,x5,3
    reset_core();
    wait_halt("jalr");
    chk("jalr_cause", 32'(bus.trap_cause), 32'd2);
    chk("jalr_pc",    dut.pc_q, 32'h4);
    chk("jalr_x1",    rg(1), 32'h0);
    chk("jalr_x5",    rg(5), 32'h100);

    // ---- reset pulse in the middle of a store wait
    clear_imem();
    imem[0] = 32'h05A00293;  // addi x5,x0,0x5A
    imem[1] = 32'h00502023;  // sw x5,0(x0)
    dly = 20;
    s0 = store_cnt;
    reset_core();
    wait_dreq("rstm");
    repeat (2) @(negedge clk);
    chk("rstm_req_before", 32'(bus.data_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstm_req_drop", 32'(bus.data_req), 32'h0);
    chk("rstm_we_drop",  32'(bus.data_we), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rstm_no_store", 32'(store_cnt - s0), 32'd0);
    chk("rstm_x5_clear", rg(5), 32'h0);
    @(posedge clk);
    #1;
    chk("rstm_refetch_req",  32'(bus.inst_req), 32'h1);
    chk("rstm_refetch_addr", bus.inst_addr, 32'h0);
    wait_halt("rstm");
    chk("rstm_store_after", 32'(store_cnt - s0), 32'd1);
    chk("rstm_st_wdata", st_wdata, 32'h0000005A);
    chk("rstm_st_addr",  st_addr, 32'h0);

    chk("never_both_req", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
